nonrestoring_divider: RTL

- Sequential radix-2 non-restoring divider; the inverse datapath to the Booth multiplier in the arithmetic unit.
- Divides a Width_in-bit dividend by a Width_in-bit divisor, one quotient bit per clock.
- Uses a shifting {remainder, quotient} partial-remainder register.
- Sits beside the multiplier under the same controller; uses the same start/done handshake style.

---
 rtl/nonrestoring_divider.sv | 123 ++++++++++++
 1 files changed

// File: rtl/nonrestoring_divider.sv
// rtl/nonrestoring_divider.sv - radix-2 non-restoring sequential divider, one quotient bit per clock
// Define SIGNED_DIV_EN for two's-complement truncating division; default build is unsigned.
module nonrestoring_divider #(
   parameter int Width_in = 16,
   parameter int Width_PR = 2*Width_in+1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [Width_in-1:0] in_A,
   input  logic [Width_in-1:0] in_B,
   output logic                busy,
   output logic                done,
   output logic                div_by_zero,
   output logic [Width_in-1:0] quotient,
   output logic [Width_in-1:0] remainder
);
   localparam int CW = $clog2(Width_in + 1);

   typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

   state_t              state, state_nx;
   logic [Width_PR-1:0] pr;
   logic [Width_PR-1:0] pr_sh;
   logic [Width_in-1:0] d;
   logic [CW-1:0]       cnt;
   logic [Width_in:0]   r_cur, r_next, d_ext;
   logic [Width_in-1:0] r_fix, q_fin, r_fin;
   logic [Width_in-1:0] a_ld, b_ld;
   logic                accept, last_iter;

   assign accept    = start && (state == IDLE || state == DONE);
   assign last_iter = (cnt == CW'(Width_in - 1));
   assign busy      = (state == ITER) || (state == FIX);
   assign done      = (state == DONE);

   // R lives in the top Width_in+1 bits; the shift drops the old sign bit,
   // which is fine because the add/sub result always lands back in range.
   assign r_cur  = pr[Width_PR-1:Width_in];
   assign pr_sh  = {pr[Width_PR-2:0], 1'b0};
   assign d_ext  = {1'b0, d};
   assign r_next = r_cur[Width_in] ? pr_sh[Width_PR-1:Width_in] + d_ext
                                   : pr_sh[Width_PR-1:Width_in] - d_ext;
   assign r_fix  = r_cur[Width_in-1:0] + (r_cur[Width_in] ? d : '0);

`ifdef SIGNED_DIV_EN
   logic neg_q, neg_r;
   assign a_ld  = in_A[Width_in-1] ? -in_A : in_A;
   assign b_ld  = in_B[Width_in-1] ? -in_B : in_B;
   assign q_fin = neg_q ? -pr[Width_in-1:0] : pr[Width_in-1:0];
   assign r_fin = neg_r ? -r_fix : r_fix;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (accept) begin
         neg_q <= in_A[Width_in-1] ^ in_B[Width_in-1];
         neg_r <= in_A[Width_in-1];
      end
   end
`else
   assign a_ld  = in_A;
   assign b_ld  = in_B;
   assign q_fin = pr[Width_in-1:0];
   assign r_fin = r_fix;
`endif

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: begin
            if (!start)           state_nx = IDLE;
            else if (in_B == '0)  state_nx = DONE;
            else                  state_nx = ITER;
         end
         ITER:    if (last_iter) state_nx = FIX;
         FIX:     state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pr          <= '0;
         d           <= '0;
         cnt         <= '0;
         div_by_zero <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  pr  <= {{(Width_in+1){1'b0}}, a_ld};
                  d   <= b_ld;
                  cnt <= '0;
                  if (in_B == '0) begin
                     quotient    <= '1;
                     remainder   <= in_A;
                     div_by_zero <= 1'b1;
                  end
               end
            end
            ITER: begin
               pr  <= {r_next, pr_sh[Width_in-1:1], ~r_next[Width_in]};
               cnt <= cnt + 1'b1;
            end
            FIX: begin
               quotient    <= q_fin;
               remainder   <= r_fin;
               div_by_zero <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule
